fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2, fetch buffer entries; legal values 2 or 4 only.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall_f_i  input  1  from hazard unit: hold PC, no new imem request issued.
REQ-006 stall_d_i  input  1  from hazard unit: hold IF/ID outputs.
REQ-007 flush_d_i  input  1  from hazard unit: invalidate IF/ID outputs.
REQ-008 pc_src_e_i  input  1  branch taken or jump resolved in EX.
REQ-009 pc_target_e_i  input  32  redirect PC.
REQ-010 imem_req_valid_o  output  1  instruction read request.
REQ-011 imem_req_addr_o  output  32  word-aligned request address.
REQ-012 imem_req_ready_i  input  1  memory accepts request.
REQ-013 imem_rsp_valid_i  input  1  read data valid; always held high by memory, no backpressure.
REQ-014 imem_rsp_data_i  input  32  instruction word.
REQ-015 instr_d_o  output  32  instruction for decode.
REQ-016 pc_d_o  output  32  PC of instr_d_o.
REQ-017 pc_plus4_d_o  output  32  pc_d_o + 4.
REQ-018 valid_d_o  output  1  instr_d_o valid; 0 is a bubble.

Function
REQ-019 Request FSM states: RUN (none outstanding), WAIT (one outstanding, live), DROP (one outstanding, killed); max one outstanding.
REQ-020 imem_req_valid_o = RUN & !stall_f_i & !pc_src_e_i & (fifo_count < FIFO_DEPTH); imem_req_addr_o = pc_f.
REQ-021 Handshake (valid & ready): req_pc <= pc_f, pc_f <= pc_f + 4 (mod 2^32 wrap), RUN -> WAIT.
REQ-022 WAIT & imem_rsp_valid_i & !pc_src_e_i: push {req_pc, data} into FIFO, -> RUN; next request no earlier than next cycle.
REQ-023 DROP & imem_rsp_valid_i: discard data, -> RUN.
REQ-024 Redirect (pc_src_e_i=1) highest priority: pc_f <= pc_target_e_i; FIFO emptied; WAIT without response -> DROP; WAIT with response same cycle -> RUN, data discarded; DROP stays DROP unless response same cycle (-> RUN); overrides stall_f_i.
REQ-025 pc_target_e_i[1:0] ignored; pc_f always has bits [1:0]=0.
REQ-026 FIFO push on full is impossible by REQ-020 construction; verification asserts it.
REQ-027 IF/ID register priority: flush_d_i -> valid_d_o<=0 (no pop); else stall_d_i -> hold all, no pop; else FIFO non-empty -> load head, pop, valid_d_o<=1; else valid_d_o<=0.
REQ-028 Push and pop same cycle allowed; count unchanged; pop sees head before push.
REQ-029 Empty FIFO with WAIT response: instruction reaches IF/ID earliest one cycle after response (FIFO registered, no bypass).
REQ-030 Zero-wait memory (ready=1, response cycle after accept): sustained throughput one instruction per 2 cycles.
REQ-031 pc_plus4_d_o computed from pc_d_o, 32-bit wrap.

Reset
REQ-032 rst=1: pc_f<=RESET_PC, FSM<=RUN, FIFO empty, valid_d_o<=0, instr_d_o<=32'h0000_0013 (NOP), pc_d_o<=0, pc_plus4_d_o<=4.
REQ-033 Reset overrides all inputs; response for a request outstanding at reset is not returned by memory (memory resets together); first request issued cycle after rst deasserts.

Verification
REQ-034 Reset, zero-wait memory returning addr as data -> first request addr RESET_PC one cycle after rst low; valid_d_o=1 with pc_d_o=RESET_PC, instr_d_o=RESET_PC three cycles after rst low.
REQ-035 Memory with 3-cycle response, 4 sequential fetches from 0 -> pc_d_o sequence 0,4,8,C, no duplicates or gaps, valid_d_o low between.
REQ-036 Request at 0x10 outstanding (WAIT), pc_src_e_i=1 target 0x100 -> state DROP, response for 0x10 discarded, next request addr 0x100, first valid pc_d_o=0x100.
REQ-037 FIFO holds 0x20,0x24, stall_d_i=1 and stall_f_i=1 for 3 cycles -> IF/ID outputs frozen, no request issued, FIFO count stays 2; after release pc_d_o 0x20 then 0x24.
REQ-038 stall_d_i=1 and flush_d_i=1 same cycle -> valid_d_o=0 next cycle, FIFO not popped.
REQ-039 pc_target_e_i=0xFFFF_FFFC -> fetch at 0xFFFF_FFFC then 0x0000_0000; pc_plus4_d_o=0 for first.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues at most one outstanding
//            instruction-memory read, queues returned words in a small
//            registered FIFO and feeds the IF/ID pipeline register.
//            EX-stage redirects cancel the in-flight read and empty the FIFO.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            stall_f_i, stall_d_i,
//            flush_d_i                - hazard-unit controls
//            pc_src_e_i, pc_target_e_i- redirect from EX
//            imem_req_*               - request channel (valid/ready/addr)
//            imem_rsp_*               - response channel (valid/data)
//            instr_d_o, pc_d_o,
//            pc_plus4_d_o, valid_d_o  - IF/ID outputs to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        pc_src_e_i,
    input  logic [31:0] pc_target_e_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc_plus4_d_o,
    output logic        valid_d_o
);

    localparam int               C_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [C_PTR_W:0] C_DEPTH = (C_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]      C_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,  // nothing outstanding
        S_WAIT = 2'd1,  // one read outstanding, result wanted
        S_DROP = 2'd2   // one read outstanding, result to be discarded
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc_f;
    logic [31:0]        r_req_pc;
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W:0]   r_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_unused_ok;

    // The redirect target is always treated as word aligned.
    assign w_unused_ok = &{1'b0, pc_target_e_i[1:0]};

    assign w_fifo_full  = (r_count == C_DEPTH);
    assign w_fifo_empty = (r_count == '0);

    // A request is only offered when the FIFO is guaranteed room for its
    // response, so a push can never land on a full FIFO.
    assign w_req_valid = (r_state == S_RUN) & ~stall_f_i & ~pc_src_e_i & ~w_fifo_full;
    assign w_req_fire  = w_req_valid & imem_req_ready_i;
    assign w_push      = (r_state == S_WAIT) & imem_rsp_valid_i & ~pc_src_e_i;
    assign w_pop       = ~flush_d_i & ~stall_d_i & ~w_fifo_empty;

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_pc_f;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving with a redirect is simply not pushed.
                if (imem_rsp_valid_i) begin
                    w_state_nxt = S_RUN;
                end else if (pc_src_e_i) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC and address of the outstanding request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f   <= {RESET_PC[31:2], 2'b00};
            r_req_pc <= {RESET_PC[31:2], 2'b00};
        end else if (pc_src_e_i) begin
            r_pc_f <= {pc_target_e_i[31:2], 2'b00};
        end else if (w_req_fire) begin
            r_req_pc <= r_pc_f;
            r_pc_f   <= r_pc_f + 32'd4;
        end
    end

    // ------------------------------------------------------------------
    // Fetch buffer: storage (no reset needed) and pointers/occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || pc_src_e_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: flush beats stall beats load
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d_o <= 1'b0;
            instr_d_o <= C_NOP;
            pc_d_o    <= 32'h0000_0000;
        end else if (flush_d_i) begin
            valid_d_o <= 1'b0;
        end else if (stall_d_i) begin
            valid_d_o <= valid_d_o;
        end else if (!w_fifo_empty) begin
            valid_d_o <= 1'b1;
            instr_d_o <= r_fifo_instr[r_rd_ptr];
            pc_d_o    <= r_fifo_pc[r_rd_ptr];
        end else begin
            valid_d_o <= 1'b0;
        end
    end

    assign pc_plus4_d_o = pc_d_o + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit. A behavioural
//            instruction memory returns the request address as data after
//            a programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_f_i = 1'b0;
    logic        stall_d_i = 1'b0;
    logic        flush_d_i = 1'b0;
    logic        pc_src_e_i = 1'b0;
    logic [31:0] pc_target_e_i = 32'h0;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b1;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = 32'h0;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc_plus4_d_o;
    logic        valid_d_o;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_f_i        (stall_f_i),
        .stall_d_i        (stall_d_i),
        .flush_d_i        (flush_d_i),
        .pc_src_e_i       (pc_src_e_i),
        .pc_target_e_i    (pc_target_e_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_d_o        (instr_d_o),
        .pc_d_o           (pc_d_o),
        .pc_plus4_d_o     (pc_plus4_d_o),
        .valid_d_o        (valid_d_o)
    );

    int          checks   = 0;
    int          failures = 0;
    int          mem_lat  = 1;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr  = 32'h0;
    int          pend_wait  = 0;
    logic [31:0] issued [$];
    logic        push_full_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: memory drives its response, requests are observed
    // mid-cycle, then time advances to just after the next rising edge.
    task automatic step();
        if (rst) begin
            imem_rsp_valid_i = 1'b0;
            pend_valid       = 1'b0;
        end else if (pend_valid && pend_wait <= 1) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = pend_addr;
            pend_valid       = 1'b0;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = 32'h0;
            if (pend_valid) pend_wait--;
        end
        #1;
        if (!rst && imem_req_valid_o && imem_req_ready_i) begin
            pend_valid = 1'b1;
            pend_addr  = imem_req_addr_o;
            pend_wait  = mem_lat;
            issued.push_back(imem_req_addr_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        stall_f_i  = 1'b0;
        stall_d_i  = 1'b0;
        flush_d_i  = 1'b0;
        pc_src_e_i = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        issued.delete();
    endtask

    function automatic logic [31:0] issued_at(input int k);
        return (k < issued.size()) ? issued[k] : 32'hDEAD_BEEF;
    endfunction

    always @(negedge clk) begin
        if (!rst && dut.w_push && (32'(dut.r_count) == 32'(FIFO_DEPTH)))
            push_full_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen_pc [$];
        logic [31:0] seen_in [$];
        logic        prev_v;
        int          b2b;
        logic        found;

        // ---------------- reset values + first fetch, zero-wait memory
        mem_lat = 1;
        do_reset();
        check("rst_valid", 32'(valid_d_o), 32'd0);
        check("rst_instr", instr_d_o, 32'h0000_0013);
        check("rst_pc", pc_d_o, 32'h0);
        check("rst_pc4", pc_plus4_d_o, 32'h4);
        check("rst_cnt", 32'(dut.r_count), 32'd0);
        step();
        check("first_req_cnt", 32'(issued.size()), 32'd1);
        check("first_req_addr", issued_at(0), 32'h0);
        check("first_c1_valid", 32'(valid_d_o), 32'd0);
        step();
        check("first_c2_valid", 32'(valid_d_o), 32'd0);
        step();
        check("first_c3_valid", 32'(valid_d_o), 32'd1);
        check("first_c3_pc", pc_d_o, 32'h0);
        check("first_c3_instr", instr_d_o, 32'h0);
        step();
        check("tput_c4_valid", 32'(valid_d_o), 32'd0);
        step();
        check("tput_c5_valid", 32'(valid_d_o), 32'd1);
        check("tput_c5_pc", pc_d_o, 32'h4);

        // ---------------- 3-cycle memory, sequential fetches
        mem_lat = 3;
        do_reset();
        prev_v = 1'b0;
        b2b    = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (valid_d_o) begin
                seen_pc.push_back(pc_d_o);
                seen_in.push_back(instr_d_o);
                if (prev_v) b2b++;
            end
            prev_v = valid_d_o;
        end
        check("seq_count", 32'(seen_pc.size()), 32'd4);
        check("seq_b2b", 32'(b2b), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("seq_pc", (k < seen_pc.size()) ? seen_pc[k] : 32'hDEAD_BEEF, 32'(4 * k));
            check("seq_instr", (k < seen_in.size()) ? seen_in[k] : 32'hDEAD_BEEF, 32'(4 * k));
        end

        // ---------------- redirect while read of 0x10 is outstanding
        issued.delete();
        pc_src_e_i    = 1'b1;
        pc_target_e_i = 32'h0000_0100;
        flush_d_i     = 1'b1;
        step();
        check("redir_state_drop", 32'(dut.r_state), 32'd2);
        check("redir_no_req", 32'(issued.size()), 32'd0);
        pc_src_e_i = 1'b0;
        flush_d_i  = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (valid_d_o) found = 1'b1;
        end
        check("redir_found", 32'(found), 32'd1);
        check("redir_pc", pc_d_o, 32'h0000_0100);
        check("redir_instr", instr_d_o, 32'h0000_0100);
        check("redir_req_addr", issued_at(0), 32'h0000_0100);

        // ---------------- fill FIFO with 0x20/0x24, then stall both stages
        mem_lat = 1;
        do_reset();
        pc_src_e_i    = 1'b1;
        pc_target_e_i = 32'h0000_0023;   // low bits must be ignored
        stall_d_i     = 1'b1;
        step();
        pc_src_e_i = 1'b0;
        repeat (4) step();
        check("fill_cnt", 32'(dut.r_count), 32'd2);
        issued.delete();
        stall_f_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_cnt", 32'(dut.r_count), 32'd2);
            check("stall_valid", 32'(valid_d_o), 32'd0);
            check("stall_pc", pc_d_o, 32'h0);
        end
        check("stall_no_req", 32'(issued.size()), 32'd0);
        stall_f_i = 1'b0;
        stall_d_i = 1'b0;
        step();
        check("rel1_valid", 32'(valid_d_o), 32'd1);
        check("rel1_pc", pc_d_o, 32'h20);
        check("rel1_instr", instr_d_o, 32'h20);
        check("rel1_pc4", pc_plus4_d_o, 32'h24);
        step();
        check("rel2_pc", pc_d_o, 32'h24);
        step();
        check("rel3_valid", 32'(valid_d_o), 32'd0);
        step();
        check("rel4_pc", pc_d_o, 32'h28);
        step();
        check("rel5_valid", 32'(valid_d_o), 32'd0);

        // ---------------- stall and flush together: flush wins, no pop
        stall_d_i = 1'b1;
        flush_d_i = 1'b1;
        step();
        check("sf_valid", 32'(valid_d_o), 32'd0);
        check("sf_cnt", 32'(dut.r_count), 32'd1);
        stall_d_i = 1'b0;
        flush_d_i = 1'b0;
        step();
        check("sf_next_pc", pc_d_o, 32'h2C);
        check("sf_pushpop_cnt", 32'(dut.r_count), 32'd1);
        step();
        check("sf_next2_pc", pc_d_o, 32'h30);

        // ---------------- redirect empties a full FIFO
        do_reset();
        stall_d_i = 1'b1;
        repeat (5) step();
        check("clr_fill_cnt", 32'(dut.r_count), 32'd2);
        pc_src_e_i    = 1'b1;
        flush_d_i     = 1'b1;
        pc_target_e_i = 32'h0000_0200;
        step();
        check("clr_cnt", 32'(dut.r_count), 32'd0);
        pc_src_e_i = 1'b0;
        flush_d_i  = 1'b0;
        stall_d_i  = 1'b0;
        step();
        check("clr_valid", 32'(valid_d_o), 32'd0);
        step();
        step();
        check("clr_pc", pc_d_o, 32'h0000_0200);

        // ---------------- wrap at top of address space
        do_reset();
        pc_src_e_i    = 1'b1;
        flush_d_i     = 1'b1;
        pc_target_e_i = 32'hFFFF_FFFC;
        step();
        pc_src_e_i = 1'b0;
        flush_d_i  = 1'b0;
        step();
        step();
        step();
        check("wrap_valid", 32'(valid_d_o), 32'd1);
        check("wrap_pc", pc_d_o, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4_d_o, 32'h0);
        check("wrap_instr", instr_d_o, 32'hFFFF_FFFC);
        step();
        step();
        check("wrap2_pc", pc_d_o, 32'h0);
        check("wrap2_pc4", pc_plus4_d_o, 32'h4);
        check("wrap_req0", issued_at(0), 32'hFFFF_FFFC);
        check("wrap_req1", issued_at(1), 32'h0);

        check("push_on_full", 32'(push_full_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
